// File: rtl/mem_port_pkg.sv
// rtl/mem_port_pkg.sv - shared widths, address limit and FSM state type for mem_port_ctrl
package mem_port_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] ADDR_MAX = 8'hFD;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        WR,
        RESP
    } state_t;

endpackage

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - single-request memory port controller (word load/store, range check)
// Optional BYTE_ACCESS_EN: byte loads and read-modify-write byte stores.
module mem_port_ctrl
    import mem_port_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] addr_in,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    state_t state;

`ifdef BYTE_ACCESS_EN
    logic       write_r;
    logic       byte_r;
    logic [7:0] wbyte_r;
    logic       go_read;

    // Byte stores take the read path first so the neighbouring byte can be merged back.
    assign go_read = !req_write || req_byte;
`else
    logic unused_req_byte;
    logic go_read;

    assign unused_req_byte = req_byte;
    assign go_read         = !req_write;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            addr_in   <= '0;
            data_in   <= '0;
`ifdef BYTE_ACCESS_EN
            write_r   <= 1'b0;
            byte_r    <= 1'b0;
            wbyte_r   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            req_ready <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        addr_in   <= req_addr;
                        data_in   <= req_wdata;
`ifdef BYTE_ACCESS_EN
                        write_r   <= req_write;
                        byte_r    <= req_byte;
                        wbyte_r   <= req_wdata[7:0];
`endif
                        if (req_addr > ADDR_MAX) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (go_read) begin
                            state   <= RD;
                            MemRead <= 1'b1;
                        end else begin
                            state    <= WR;
                            MemWrite <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state <= RDW;
                end
                RDW: begin
`ifdef BYTE_ACCESS_EN
                    if (write_r) begin
                        state    <= WR;
                        MemWrite <= 1'b1;
                        data_in  <= {wbyte_r, data_out[7:0]};
                    end else begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= byte_r ? {8'h00, data_out[15:8]} : data_out;
                    end
`else
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= data_out;
`endif
                end
                WR: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - self-checking bench for mem_port_ctrl (vector table, reset aborts, random vs model)
`timescale 1ns/1ps
module tb_mem_port_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [7:0]  addr_in;
    logic [15:0] data_in;
    logic [15:0] data_out = '0;

    mem_port_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_byte (req_byte),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .addr_in  (addr_in),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    logic [7:0] ref_mem [0:255];

    // Memory slave: big-endian word at addr_in, read data registered one cycle.
    always @(posedge clk) begin
        if (MemWrite) begin
            mem[addr_in]        = data_in[15:8];
            mem[addr_in + 8'd1] = data_in[7:0];
        end
        if (MemRead)
            data_out <= {mem[addr_in], mem[addr_in + 8'd1]};
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [15:0] wdata;
    } exp_t;

    typedef struct {
        logic        w;
        logic        b;
        logic [7:0]  a;
        logic [15:0] wd;
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [15:0] wdata;
    } vec_t;

    // Reference: byte-array view of memory plus the latency/strobe rules per access kind.
    function automatic exp_t model(input logic w, input logic b, input logic [7:0] a, input logic [15:0] wd);
        exp_t e;
        logic bm;
        logic [7:0] a1;
        a1 = a + 8'd1;
`ifdef BYTE_ACCESS_EN
        bm = b;
`else
        bm = 1'b0 & b;
`endif
        e.rdata = '0; e.err = 1'b0; e.lat = 0; e.nrd = 0; e.nwr = 0; e.wdata = '0;
        if (a > 8'hFD) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (!w) begin
            e.lat = 3;
            e.nrd = 1;
            e.rdata = bm ? {8'h00, ref_mem[a]} : {ref_mem[a], ref_mem[a1]};
        end else if (bm) begin
            e.lat = 4; e.nrd = 1; e.nwr = 1;
            e.wdata = {wd[7:0], ref_mem[a1]};
            ref_mem[a] = wd[7:0];
        end else begin
            e.lat = 2; e.nwr = 1;
            e.wdata = wd;
            ref_mem[a]  = wd[15:8];
            ref_mem[a1] = wd[7:0];
        end
        return e;
    endfunction

    task automatic run_check(input string tag, input logic w, input logic b, input logic [7:0] a,
                             input logic [15:0] wd, input exp_t e);
        int waits;
        int lat;
        int nrd;
        int nwr;
        logic [15:0] wr_data;
        logic [15:0] rd;
        logic er;
        waits = 0;
        while (!req_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        check({tag, " ready"}, req_ready, 1);
        req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = wd;
        @(posedge clk);
        lat = 0; nrd = 0; nwr = 0; wr_data = '0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (MemRead && MemWrite) check({tag, " strobe_excl"}, 1, 0);
            if (MemRead) nrd++;
            if (MemWrite) begin
                nwr++;
                wr_data = data_in;
            end
            if (rsp_valid) begin
                lat = i; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
        check({tag, " rsp_seen"}, lat != 0, 1);
        check({tag, " latency"}, lat, e.lat);
        check({tag, " rdata"}, rd, e.rdata);
        check({tag, " err"}, er, e.err);
        check({tag, " n_read"}, nrd, e.nrd);
        check({tag, " n_write"}, nwr, e.nwr);
        if (e.nwr != 0) check({tag, " wdata"}, wr_data, e.wdata);
        check({tag, " addr_in"}, addr_in, a);
        @(negedge clk);
        check({tag, " rsp_one_cycle"}, rsp_valid, 0);
        check({tag, " rsp_hold"}, {er, rsp_rdata}, {e.err, e.rdata});
        check({tag, " b2b_ready"}, req_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rsp_valid"}, rsp_valid, 0);
        check({tag, " rsp_err"}, rsp_err, 0);
        check({tag, " rsp_rdata"}, rsp_rdata, 0);
        check({tag, " MemRead"}, MemRead, 0);
        check({tag, " MemWrite"}, MemWrite, 0);
        check({tag, " addr_in"}, addr_in, 0);
        check({tag, " data_in"}, data_in, 0);
    endtask

    vec_t tbl [9];

    initial begin
        exp_t e;
        exp_t d;
        int pulses;
        logic [7:0] ra;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        mem[4] = 8'h12; mem[5] = 8'h34; mem[6] = 8'hDE; mem[7] = 8'hAD;
        ref_mem[4] = 8'h12; ref_mem[5] = 8'h34; ref_mem[6] = 8'hDE; ref_mem[7] = 8'hAD;

        tbl[0] = '{1'b0, 1'b0, 8'h04, 16'h0000, 16'h1234, 1'b0, 3, 1, 0, 16'h0000};
        tbl[1] = '{1'b1, 1'b0, 8'h20, 16'hBEEF, 16'h0000, 1'b0, 2, 0, 1, 16'hBEEF};
        tbl[2] = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'hBEEF, 1'b0, 3, 1, 0, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 8'hFE, 16'h0000, 16'h0000, 1'b1, 1, 0, 0, 16'h0000};
        tbl[4] = '{1'b1, 1'b0, 8'hFF, 16'h1234, 16'h0000, 1'b1, 1, 0, 0, 16'h0000};
        tbl[5] = '{1'b0, 1'b0, 8'hFD, 16'h0000, 16'hEEF5, 1'b0, 3, 1, 0, 16'h0000};
`ifdef BYTE_ACCESS_EN
        tbl[6] = '{1'b1, 1'b1, 8'h06, 16'h0055, 16'h0000, 1'b0, 4, 1, 1, 16'h55AD};
        tbl[7] = '{1'b0, 1'b0, 8'h06, 16'h0000, 16'h55AD, 1'b0, 3, 1, 0, 16'h0000};
        tbl[8] = '{1'b0, 1'b1, 8'h07, 16'h0000, 16'h00AD, 1'b0, 3, 1, 0, 16'h0000};
`else
        tbl[6] = '{1'b1, 1'b1, 8'h06, 16'h0055, 16'h0000, 1'b0, 2, 0, 1, 16'h0055};
        tbl[7] = '{1'b0, 1'b0, 8'h06, 16'h0000, 16'h0055, 1'b0, 3, 1, 0, 16'h0000};
        tbl[8] = '{1'b0, 1'b1, 8'h07, 16'h0000, 16'h553B, 1'b0, 3, 1, 0, 16'h0000};
`endif

        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check("reset req_ready", req_ready, 1);
        check_reset_outputs("after_reset");

        for (int i = 0; i < 9; i++) begin
            d = model(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd);
            e.rdata = tbl[i].rdata; e.err = tbl[i].err; e.lat = tbl[i].lat;
            e.nrd = tbl[i].nrd; e.nwr = tbl[i].nwr; e.wdata = tbl[i].wdata;
            run_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd, e);
        end

        // Reset during RDW of a load: no response, outputs back to reset values.
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 8'h04;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort_load");
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        check("abort_load no_rsp", pulses, 0);
        e = model(1'b0, 1'b0, 8'h04, 16'h0000);
        run_check("after_abort_load", 1'b0, 1'b0, 8'h04, 16'h0000, e);

        // Reset while the write strobe is high: strobe drops without a clock edge.
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_addr = 8'h30; req_wdata = 16'hCAFE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_store strobe_up", MemWrite, 1);
        reset = 1'b0;
        #1;
        check("abort_store strobe_async", MemWrite, 0);
        check_reset_outputs("abort_store");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        e = model(1'b0, 1'b0, 8'h30, 16'h0000);
        run_check("after_abort_store", 1'b0, 1'b0, 8'h30, 16'h0000, e);

        for (int i = 0; i < 40; i++) begin
            logic w;
            logic b;
            logic [15:0] wd;
            w = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = 8'($urandom_range(252, 255));
            else ra = 8'($urandom_range(0, 63));
            e = model(w, b, ra, wd);
            run_check($sformatf("rnd%0d", i), w, b, ra, wd, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
